// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the syn_fifo write port among NUM_REQ valid/ready producers.
// Each grant lasts up to BURST_LEN words and is throttled by the FIFO full flag.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic                          fifo_full_i,
  output logic                          wr_o,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_BURST
  } state_t;

  state_t             state;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   owner;
  logic [CNT_W-1:0]   burst_cnt;
  logic               busy;

  logic [PTR_W:0]     pick;
  logic               owner_vld;
  logic               xfer;
  logic               release_burst;

  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
    return (int'(idx) == NUM_REQ - 1) ? '0 : idx + PTR_W'(1);
  endfunction

  // Returns {found, index} of the first valid requester at or after start, wrapping.
  function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                             input logic [PTR_W-1:0]   start);
    logic             found;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] cand;
    found = 1'b0;
    idx   = '0;
    cand  = start;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && vld[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
      cand = next_idx(cand);
    end
    return {found, idx};
  endfunction

  assign pick          = rr_pick(req_valid_i, ptr);
  assign owner_vld     = req_valid_i[owner];
  assign xfer          = busy & owner_vld & ~fifo_full_i;
  assign release_burst = ~owner_vld | (xfer & (burst_cnt == LAST_CNT));

  // Write side is combinational so a word moves in the same cycle it is accepted.
  assign req_ready_o = busy ? (grant & {NUM_REQ{~fifo_full_i}}) : '0;
  assign wr_o        = xfer;
  assign data_o      = xfer ? req_data_i[int'(owner)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign grant_o     = grant;
  assign busy_o      = busy;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      grant     <= '0;
      ptr       <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable_i && pick[PTR_W]) begin
            state     <= ST_BURST;
            busy      <= 1'b1;
            owner     <= pick[PTR_W-1:0];
            grant     <= NUM_REQ'(1) << pick[PTR_W-1:0];
            burst_cnt <= '0;
          end
        end
        ST_BURST: begin
          if (release_burst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            grant     <= '0;
            ptr       <= next_idx(owner);
            burst_cnt <= '0;
          end else if (xfer) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 16;
  localparam int BURST_LEN  = 4;
  localparam int QD         = 1024;

  logic                          clk = 1'b0;
  logic                          rst_i;
  logic                          enable_i;
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic                          fifo_full_i;
  logic                          wr_o;
  logic [DATA_WIDTH-1:0]         data_o;
  logic [NUM_REQ-1:0]            grant_o;
  logic                          busy_o;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_WIDTH(DATA_WIDTH),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .enable_i   (enable_i),
    .req_valid_i(req_valid_i),
    .req_data_i (req_data_i),
    .req_ready_o(req_ready_o),
    .fifo_full_i(fifo_full_i),
    .wr_o       (wr_o),
    .data_o     (data_o),
    .grant_o    (grant_o),
    .busy_o     (busy_o)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Producer word queues as arrays with head/tail indices.
  logic [DATA_WIDTH-1:0] pmem [NUM_REQ][QD];
  int head [NUM_REQ];
  int tail [NUM_REQ];

  logic               rst_s, en_s, full_s;
  logic [NUM_REQ-1:0] gate;

  // Model: current owner (-1 = nobody), rotation start, words in current grant.
  int m_owner, m_ptr, m_words;
  int dut_wr_cnt;

  logic [NUM_REQ-1:0] g_seen [32];
  logic               w_seen [32];
  int                 wcount;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic [DATA_WIDTH-1:0] w);
    if (tail[k] < QD) begin
      pmem[k][tail[k]] = w;
      tail[k]++;
    end
  endtask

  task automatic clear_q();
    for (int k = 0; k < NUM_REQ; k++) head[k] = tail[k];
  endtask

  task automatic cycle();
    logic [NUM_REQ-1:0]    vld;
    logic [NUM_REQ-1:0]    e_grant;
    logic [NUM_REQ-1:0]    e_ready;
    logic                  e_wr;
    logic [DATA_WIDTH-1:0] e_data;
    logic                  found;
    int                    sel;
    @(negedge clk);
    rst_i       = rst_s;
    enable_i    = en_s;
    fifo_full_i = full_s;
    for (int k = 0; k < NUM_REQ; k++) begin
      vld[k] = gate[k] && (head[k] != tail[k]);
      req_valid_i[k] = vld[k];
      req_data_i[k*DATA_WIDTH +: DATA_WIDTH] = vld[k] ? pmem[k][head[k]] : DATA_WIDTH'($urandom);
    end
    #1;
    if (rst_s) begin
      m_owner = -1;
      m_ptr   = 0;
      m_words = 0;
    end
    e_grant = (m_owner >= 0) ? (NUM_REQ'(1) << m_owner) : '0;
    e_ready = full_s ? '0 : e_grant;
    e_wr    = (m_owner >= 0) && vld[m_owner] && !full_s;
    e_data  = e_wr ? pmem[m_owner][head[m_owner]] : '0;
    chk("wr_o",        32'(wr_o),        32'(e_wr));
    chk("data_o",      32'(data_o),      32'(e_data));
    chk("grant_o",     32'(grant_o),     32'(e_grant));
    chk("req_ready_o", 32'(req_ready_o), 32'(e_ready));
    chk("busy_o",      32'(busy_o),      32'(m_owner >= 0));
    chk("wr_while_full", 32'(wr_o & fifo_full_i), 32'(0));
    if (wr_o === 1'b1) dut_wr_cnt++;
    if (!rst_s) begin
      if (m_owner < 0) begin
        if (en_s && vld != '0) begin
          found = 1'b0;
          for (int i = 0; i < NUM_REQ; i++) begin
            sel = (m_ptr + i) % NUM_REQ;
            if (!found && vld[sel]) begin
              found   = 1'b1;
              m_owner = sel;
            end
          end
          m_words = 0;
        end
      end else if (!vld[m_owner]) begin
        m_ptr   = (m_owner + 1) % NUM_REQ;
        m_owner = -1;
      end else if (e_wr) begin
        head[m_owner]++;
        m_words++;
        if (m_words == BURST_LEN) begin
          m_ptr   = (m_owner + 1) % NUM_REQ;
          m_owner = -1;
        end
      end
    end
  endtask

  task automatic quiesce();
    clear_q();
    repeat (3) cycle();
  endtask

  initial begin
    rst_i = 1'b1; enable_i = 1'b1; fifo_full_i = 1'b0;
    req_valid_i = '0; req_data_i = '0;
    rst_s = 1'b1; en_s = 1'b1; full_s = 1'b0; gate = '1;
    m_owner = -1; m_ptr = 0; m_words = 0; dut_wr_cnt = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      head[k] = 0;
      tail[k] = 0;
    end

    // Reset held while every requester is valid
    for (int k = 0; k < NUM_REQ; k++)
      for (int i = 0; i < 8; i++) push(k, DATA_WIDTH'(16'h1000 * (k + 1) + i));
    repeat (4) begin
      cycle();
      chk("rst_outputs", 32'({wr_o, busy_o, grant_o, req_ready_o}), 32'(0));
    end
    rst_s = 1'b0;
    cycle();
    cycle();
    chk("t1_first_grant", 32'(grant_o), 32'(4'b0001));
    quiesce();

    // Lone requester 2 sends three words then drops valid
    push(2, 16'hA001); push(2, 16'hA002); push(2, 16'hA003);
    cycle();
    chk("t2_idle_grant", 32'(grant_o), 32'(0));
    chk("t2_idle_wr", 32'(wr_o), 32'(0));
    cycle();
    chk("t2_grant", 32'(grant_o), 32'(4'b0100));
    chk("t2_w1", 32'({wr_o, data_o}), 32'({1'b1, 16'hA001}));
    cycle();
    chk("t2_w2", 32'({wr_o, data_o}), 32'({1'b1, 16'hA002}));
    cycle();
    chk("t2_w3", 32'({wr_o, data_o}), 32'({1'b1, 16'hA003}));
    cycle();
    chk("t2_nowr", 32'(wr_o), 32'(0));
    cycle();
    chk("t2_idle_after", 32'(busy_o), 32'(0));
    push(0, 16'hB0B0); push(3, 16'hC3C3);
    cycle();
    cycle();
    chk("t2_ptr3", 32'(grant_o), 32'(4'b1000));
    quiesce();

    // All four continuously valid: rotation and throughput
    for (int k = 0; k < NUM_REQ; k++)
      for (int i = 0; i < 5; i++) push(k, DATA_WIDTH'(16'h2000 + k * 16 + i));
    for (int c = 0; c < 22; c++) begin
      cycle();
      g_seen[c] = grant_o;
      w_seen[c] = wr_o;
    end
    wcount = 0;
    for (int c = 0; c < 20; c++) if (w_seen[c] === 1'b1) wcount++;
    chk("t3_words_in_20", 32'(wcount), 32'(16));
    chk("t3_own0", 32'(g_seen[1]),  32'(4'b0001));
    chk("t3_own1", 32'(g_seen[6]),  32'(4'b0010));
    chk("t3_own2", 32'(g_seen[11]), 32'(4'b0100));
    chk("t3_own3", 32'(g_seen[16]), 32'(4'b1000));
    chk("t3_own0_again", 32'(g_seen[21]), 32'(4'b0001));
    chk("t3_gaps", 32'({w_seen[5], w_seen[10], w_seen[15]}), 32'(0));
    quiesce();

    // FIFO full for three cycles after the second word
    for (int i = 1; i <= 4; i++) push(1, DATA_WIDTH'(16'hD000 + i));
    cycle();
    cycle();
    chk("t4_w1", 32'({wr_o, data_o}), 32'({1'b1, 16'hD001}));
    cycle();
    chk("t4_w2", 32'({wr_o, data_o}), 32'({1'b1, 16'hD002}));
    full_s = 1'b1;
    repeat (3) begin
      cycle();
      chk("t4_stall", 32'({wr_o, req_ready_o, grant_o}), 32'({1'b0, 4'b0000, 4'b0010}));
    end
    full_s = 1'b0;
    cycle();
    chk("t4_w3", 32'({wr_o, data_o}), 32'({1'b1, 16'hD003}));
    cycle();
    chk("t4_w4", 32'({wr_o, data_o}), 32'({1'b1, 16'hD004}));
    cycle();
    chk("t4_released", 32'({busy_o, grant_o}), 32'(0));
    quiesce();

    // enable_i dropped during a burst
    for (int k = 0; k < NUM_REQ; k++)
      for (int i = 0; i < 8; i++) push(k, DATA_WIDTH'(16'h3000 + k * 16 + i));
    cycle();
    en_s = 1'b0;
    dut_wr_cnt = 0;
    cycle();
    chk("t5_grant", 32'(grant_o), 32'(4'b0100));
    repeat (8) cycle();
    chk("t5_burst_words", 32'(dut_wr_cnt), 32'(4));
    chk("t5_no_new_grant", 32'({busy_o, grant_o}), 32'(0));
    en_s = 1'b1;
    cycle();
    cycle();
    chk("t5_next_owner", 32'(grant_o), 32'(4'b1000));
    quiesce();

    // Reset pulse after two words of requester 1
    for (int i = 1; i <= 4; i++) push(1, DATA_WIDTH'(16'hE000 + i));
    cycle();
    dut_wr_cnt = 0;
    cycle();
    cycle();
    rst_s = 1'b1;
    cycle();
    chk("t6_rst_outputs", 32'({wr_o, busy_o, grant_o, req_ready_o, data_o}), 32'(0));
    chk("t6_words_kept", 32'(dut_wr_cnt), 32'(2));
    rst_s = 1'b0;
    push(0, 16'hF000);
    cycle();
    cycle();
    chk("t6_grant_req0", 32'(grant_o), 32'(4'b0001));
    quiesce();

    // Random traffic against the model
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if ((tail[k] - head[k]) < 3 && $urandom_range(0, 2) == 0) push(k, DATA_WIDTH'($urandom));
        gate[k] = ($urandom_range(0, 9) != 0);
      end
      full_s = ($urandom_range(0, 3) == 0);
      en_s   = ($urandom_range(0, 9) != 0);
      rst_s  = ($urandom_range(0, 299) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
